// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front end and the command RAM.
package spi_pkg;

    localparam int unsigned FRAME_W_DEF = 10;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4
    } spi_state_e;

    // Frame bits [9:8], decoded by the RAM
    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } spi_cmd_e;

endpackage

// File: rtl/spi_tx_piso.sv
// Parallel-load, serial-out MSB-first shifter driving MISO; output is 0 when idle.
module spi_tx_piso
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              miso_o,
    output logic              done_c
);

    localparam int unsigned REM_W = $clog2(DATA_W);

    logic [DATA_W-1:0] sh_q;
    logic [REM_W-1:0]  rem_q;
    logic              busy_q;
    logic              miso_q;

    always_ff @(posedge CLK) begin
        if (!rst_n || clr_i) begin
            sh_q   <= '0;
            rem_q  <= '0;
            busy_q <= 1'b0;
            miso_q <= 1'b0;
        end else if (load_i) begin
            miso_q <= data_i[DATA_W-1];
            sh_q   <= {data_i[DATA_W-2:0], 1'b0};
            rem_q  <= REM_W'(DATA_W - 1);
            busy_q <= 1'b1;
        end else if (en_i && busy_q) begin
            if (rem_q == '0) begin
                miso_q <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                miso_q <= sh_q[DATA_W-1];
                sh_q   <= {sh_q[DATA_W-2:0], 1'b0};
                rem_q  <= rem_q - REM_W'(1);
            end
        end
    end

    assign miso_o = miso_q;
    // High during the cycle the last data bit is on MISO
    assign done_c = busy_q && (rem_q == '0);

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: MOSI frames to RAM command words, RAM read data back out on MISO.
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    spi_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FRAME_W-2:0] rx_sh_q;
    logic [FRAME_W-1:0] rx_sh_d;
    logic [FRAME_W-1:0] rx_data_q;
    logic               rx_valid_q;
    logic               rd_addr_ok_q;
    logic               samp_q;
    logic               load_c;
    logic               tx_done_c;

    assign rx_sh_d = {rx_sh_q, MOSI};
    // tx_valid only counts in the single cycle after a READ_DATA frame completes
    assign load_c  = samp_q && tx_valid && !SS_n;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rx_sh_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rd_addr_ok_q <= 1'b0;
            samp_q       <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            samp_q     <= 1'b0;
            if (SS_n) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_CHK_CMD;
                        cnt_q   <= '0;
                    end
                    ST_CHK_CMD: begin
                        if (!MOSI)
                            state_q <= ST_WRITE;
                        else if (rd_addr_ok_q)
                            state_q <= ST_READ_DATA;
                        else
                            state_q <= ST_READ_ADD;
                    end
                    ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                        // Counter saturates at FRAME_W; extra MOSI bits are ignored
                        if (cnt_q != CNT_W'(FRAME_W)) begin
                            rx_sh_q <= rx_sh_d[FRAME_W-2:0];
                            cnt_q   <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                                rx_data_q  <= rx_sh_d;
                                rx_valid_q <= 1'b1;
                                if (state_q == ST_READ_ADD)
                                    rd_addr_ok_q <= 1'b1;
                            end
                        end
                        if (state_q == ST_READ_DATA && rx_valid_q)
                            samp_q <= 1'b1;
                        if (state_q == ST_READ_DATA && tx_done_c)
                            rd_addr_ok_q <= 1'b0;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    spi_tx_piso #(
        .DATA_W (DATA_W)
    ) u_tx_piso (
        .CLK    (CLK),
        .rst_n  (rst_n),
        .load_i (load_c),
        .en_i   (!SS_n),
        .clr_i  (SS_n),
        .data_i (tx_data),
        .miso_o (MISO),
        .done_c (tx_done_c)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

SPI slave front end for the single-port command RAM. Deserializes MOSI frames into 10-bit command words for the RAM (`din`/`rx_valid`) and serializes the RAM's 8-bit read data (`dout`/`tx_valid`) back out on MISO. The SPI clock is the system clock `CLK` (no clock-domain crossing). Sits directly upstream of, and returns data from, the RAM.

## Interface
- `FRAME_W`, 10, width of the command word delivered to the RAM
- `DATA_W`, 8, width of read data returned by the RAM
- `CLK`  in  1  system clock = SPI clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset; sampled on rising `CLK`
- `SS_n`  in  1  slave select, active low; high = bus idle
- `MOSI`  in  1  serial data in, MSB first, sampled on rising `CLK`
- `MISO`  out  1  serial data out, MSB first, registered
- `rx_data`  out  FRAME_W  assembled command word; connects to RAM `din`
- `rx_valid`  out  1  one-cycle pulse; `rx_data` valid
- `tx_data`  in  DATA_W  RAM read data (`dout`)
- `tx_valid`  in  1  RAM read-data valid; level signal, may stay high across frames

## Operation
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- Flag `rd_addr_ok` (internal register): set when a READ_ADD frame completes; cleared when a READ_DATA frame completes its MISO shift.
- IDLE: `SS_n`=0 -> CHK_CMD; otherwise stay.
- CHK_CMD: the `MOSI` bit sampled this cycle is the direction bit and is not shifted into `rx_data`.
  - `MOSI`=0 -> WRITE.
  - `MOSI`=1 and `rd_addr_ok`=0 -> READ_ADD.
  - `MOSI`=1 and `rd_addr_ok`=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA:
  - Shift exactly FRAME_W `MOSI` bits MSB-first into the shift register; a 4-bit counter tracks bits.
  - After the 10th bit: `rx_data` = shift register and `rx_valid`=1 for exactly one cycle.
  - Further MOSI bits are ignored until `SS_n` rises.
  - Bits [9:8] are forwarded unchecked; the RAM decodes them.
- READ_DATA return path:
  - In the cycle after the `rx_valid` pulse, sample `tx_valid`.
  - If 1: load `tx_data` into the output shift register and drive DATA_W bits on MISO, MSB first, one per cycle. Then clear `rd_addr_ok`.
  - If 0: no shift-out, MISO stays 0, and `rd_addr_ok` is kept.
  - `tx_valid` at any other time is ignored. This discards stale sticky `tx_valid` from a previous read.
- MISO = 0 whenever not shifting read data.
- Any state, `SS_n`=1 -> IDLE on the next edge. Counters and shift-out are cleared; `rx_valid` is not issued for a partial frame; `rd_addr_ok` is unchanged.
- Counter never wraps: it saturates at frame completion until IDLE.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `rx_data`=0, `rx_valid`=0, `MISO`=0, `rd_addr_ok`=0, counters 0. Applies mid-frame too; the next frame needs a fresh `SS_n` falling transition through IDLE.
- Let C0 be the first cycle with `SS_n`=0:
  - C0: IDLE -> CHK_CMD.
  - C1: direction bit sampled.
  - C2..C11: frame bits 9..0.
  - C12: `rx_vali d` high (registered).
- READ_DATA:
  - C12: `rx_valid`.
  - C13: RAM presents `tx_valid`/`tx_data`; the controller samples them.
  - C14..C21: MISO = `tx_data[7]`..`tx_data[0]`.
  - C22: MISO = 0.
- Master must hold `SS_n` low through C21 for a read, and through C12 for write/read-address.
- `SS_n` rising during C14..C21 aborts shift-out immediately (MISO 0 next edge), and `rd_addr_ok` is kept.

## Structure
- Shared package `spi_pkg`:
  - state enum/localparams (IDLE=0, CHK_CMD=1, WRITE=2, READ_ADD=3, READ_DATA=4)
  - FRAME_W/DATA_W defaults
  - command codes 2'b00/01/10/11, shared with the RAM
- One natural sub-module: `spi_tx_piso` (DATA_W parallel-load, serial-out MSB-first, load/enable/clear, sync active-low reset). All other logic lives in the top FSM.

## Test plan
- Reset mid-frame: assert `rst_n`=0 at C6 of a write frame -> next edge `rx_valid`=0, `MISO`=0, state IDLE; no pulse at C12.
- Write address: `SS_n`=0, MOSI 0 then 00_0101_0101 -> `rx_data`=10'h055, `rx_valid` high exactly one cycle at C12.
- Write data: MOSI 0 then 01_1010_1010 -> `rx_data`=10'h1AA, single pulse; `rd_addr_ok` stays 0.
- Read sequence: MOSI 1 + 10_0000_0011 -> READ_ADD, `rx_data`=10'h203, `rd_addr_ok`=1. Next frame MOSI 1 + 11_xxxx_xxxx -> READ_DATA; RAM model returns 8'hAA with `tx_valid` at C13 -> MISO 1,0,1,0,1,0,1,0 over C14..C21, then `rd_addr_ok`=0.
- Stale `tx_valid`: hold `tx_valid`=1 throughout a write frame and a read-address frame -> MISO remains 0 at all times.
- Abort: `SS_n` rises after 5 frame bits -> no `rx_valid`, IDLE next edge. A following full write frame decodes correctly, e.g. 10'h0FF.
